// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared FSM states and constants for the writeback arbiter
package regfile_wb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ARB, INIT} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int INIT_STRIDE = 4;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin arbiter; the last-grant memory moves only on an accepted tie
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic gnt0,
  output logic gnt1
);
  logic rr_last_q, rr_last_d;
  always_comb begin
    gnt0 = req0 && (!req1 || rr_last_q);
    gnt1 = req1 && (!req0 || !rr_last_q);
    rr_last_d = upd ? gnt1 : rr_last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last_q <= 1'b1;
    else rr_last_q <= rr_last_d;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between two requesters plus an init walk; REGFILE_WB_ARB_FWD_EN adds fwd_addr/fwd_hit/fwd_data
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              init_start,
  output logic              init_busy,
  output logic              regWriteEn,
  output logic [ADDR_W-1:0] regWriteAddr,
`ifdef REGFILE_WB_ARB_FWD_EN
  output logic [DATA_W-1:0] regWriteData,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`else
  output logic [DATA_W-1:0] regWriteData
`endif
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, waddr_q, waddr_d, sel_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, sel_data;
  logic we_q, we_d, gnt0, gnt1, en, acc0, acc1, acc, upd;
  rr_arb2 u_arb (
    .clk (clkin),
    .rst (reset),
    .req0(req0_valid),
    .req1(req1_valid),
    .upd (upd),
    .gnt0(gnt0),
    .gnt1(gnt1)
  );
  always_comb begin
    en = (state_q != INIT) && !init_start;
    req0_ready = en && gnt0;
    req1_ready = en && gnt1;
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    acc = acc0 || acc1;
    upd = acc && req0_valid && req1_valid;
    sel_addr = acc1 ? req1_addr : req0_addr;
    sel_data = acc1 ? req1_data : req0_data;
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (state_q == INIT) begin
      if (we_q && waddr_q == LAST) begin
        state_d = IDLE;
        cnt_d = '0;
      end else begin
        we_d = 1'b1;
        waddr_d = cnt_q;
        wdata_d = DATA_W'(cnt_q) * DATA_W'(INIT_STRIDE);
        cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + ADDR_W'(1);
      end
    end else if (init_start) begin
      state_d = INIT;
      we_d = 1'b1;
      waddr_d = '0;
      wdata_d = '0;
      cnt_d = ADDR_W'(1);
    end else begin
      state_d = (req0_valid || req1_valid) ? ARB : IDLE;
      we_d = acc && (sel_addr != ADDR_W'(REG_ZERO));
      waddr_d = acc ? sel_addr : waddr_q;
      wdata_d = acc ? sel_data : wdata_q;
    end
  end
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  assign init_busy = (state_q == INIT);
  assign regWriteEn = we_q;
  assign regWriteAddr = waddr_q;
  assign regWriteData = wdata_q;
`ifdef REGFILE_WB_ARB_FWD_EN
  assign fwd_hit = we_q && (waddr_q == fwd_addr) && (fwd_addr != '0);
  assign fwd_data = fwd_hit ? wdata_q : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clkin = 1'b0;
  logic reset = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, init_start = 1'b0;
  logic [4:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, init_busy, regWriteEn;
  logic [4:0] regWriteAddr;
  logic [31:0] regWriteData;
  int vecs = 0, errs = 0;
`ifdef REGFILE_WB_ARB_FWD_EN
  logic [4:0] fwd_addr = '0;
  logic fwd_hit;
  logic [31:0] fwd_data;
`endif
  regfile_wb_arbiter dut (
    .clkin(clkin),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_addr(req0_addr),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr(req1_addr),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .init_start(init_start),
    .init_busy(init_busy),
    .regWriteEn(regWriteEn),
    .regWriteAddr(regWriteAddr),
`ifdef REGFILE_WB_ARB_FWD_EN
    .regWriteData(regWriteData),
    .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
`else
    .regWriteData(regWriteData)
`endif
  );
  always #5 clkin = ~clkin;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask
  initial begin
    logic [4:0] a0, a1, ea;
    logic [31:0] d0, d1, ed;
    #1 reset = 1'b1;
    #3;
    chk("rst_we", 32'(regWriteEn), 0);
    chk("rst_addr", 32'(regWriteAddr), 0);
    chk("rst_data", regWriteData, 0);
    chk("rst_busy", 32'(init_busy), 0);
    @(negedge clkin) reset = 1'b0;
    tick();
    init_start = 1'b1;
    req0_valid = 1'b1;
    req0_addr = 5'd3;
    req0_data = 32'h33;
    #1;
    chk("init_vs_req_ready", 32'(req0_ready), 0);
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("walk_busy", 32'(init_busy), 1);
      chk("walk_we", 32'(regWriteEn), 1);
      chk("walk_addr", 32'(regWriteAddr), 32'(i));
      chk("walk_data", regWriteData, 32'(4 * i));
      chk("walk_ready", 32'(req0_ready), 0);
      tick();
    end
    chk("walk_end_busy", 32'(init_busy), 0);
    chk("walk_end_we", 32'(regWriteEn), 0);
    chk("post_init_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    chk("pend_we", 32'(regWriteEn), 1);
    chk("pend_addr", 32'(regWriteAddr), 3);
    chk("pend_data", regWriteData, 32'h33);
    req0_valid = 1'b1;
    req0_addr = 5'd5;
    req0_data = 32'hDEADBEEF;
    #1;
    chk("r0_ready", 32'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    chk("r0_we", 32'(regWriteEn), 1);
    chk("r0_addr", 32'(regWriteAddr), 5);
    chk("r0_data", regWriteData, 32'hDEADBEEF);
    tick();
    chk("r0_we_off", 32'(regWriteEn), 0);
    a0 = 5'd10; d0 = 32'hA000_0010;
    a1 = 5'd11; d1 = 32'hB000_0011;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_addr = a0; req0_data = d0;
      req1_addr = a1; req1_data = d1;
      #1;
      chk("rr_ready0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("rr_ready1", 32'(req1_ready), 32'(k % 2 == 1));
      ea = (k % 2 == 0) ? a0 : a1;
      ed = (k % 2 == 0) ? d0 : d1;
      tick();
      chk("rr_we", 32'(regWriteEn), 1);
      chk("rr_addr", 32'(regWriteAddr), 32'(ea));
      chk("rr_data", regWriteData, ed);
      if (k % 2 == 0) begin a0 = a0 + 5'd2; d0 = d0 + 32'h100; end
      else begin a1 = a1 + 5'd2; d1 = d1 + 32'h100; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("rr_idle_we", 32'(regWriteEn), 0);
    req1_valid = 1'b1;
    req1_addr = 5'd0;
    req1_data = 32'h1234;
    #1;
    chk("z_ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    chk("z_we", 32'(regWriteEn), 0);
    tick();
    chk("z_we2", 32'(regWriteEn), 0);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_addr", 32'(regWriteAddr), 10);
    chk("mid_busy", 32'(init_busy), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(regWriteEn), 0);
    chk("mid_rst_addr", 32'(regWriteAddr), 0);
    chk("mid_rst_data", regWriteData, 0);
    chk("mid_rst_busy", 32'(init_busy), 0);
    @(negedge clkin) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("after_rst_we", 32'(regWriteEn), 0);
      chk("after_rst_busy", 32'(init_busy), 0);
    end
`ifdef REGFILE_WB_ARB_FWD_EN
    fwd_addr = 5'd7;
    req0_valid = 1'b1;
    req0_addr = 5'd7;
    req0_data = 32'hC0FFEE07;
    tick();
    req0_valid = 1'b0;
    chk("fwd_hit", 32'(fwd_hit), 1);
    chk("fwd_data", fwd_data, 32'hC0FFEE07);
    tick();
    chk("fwd_miss", 32'(fwd_hit), 0);
    chk("fwd_miss_data", fwd_data, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
